// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
//   Receive-side PRBS31 (x^31 + x^28 + 1) checker. Loads 31 received bits,
//   self-synchronises on the incoming stream until LOCK_COUNT consecutive bits
//   agree with the prediction, then switches to a free-running local replica
//   and counts bit errors. Lock is dropped when LOSS_THRESH errors land inside
//   one 2^WIN_LOG2-bit window.
//
// Ports
//   i_clk        clock, all state changes on rising edge
//   i_rst_n      asynchronous reset, active HIGH (name kept from the generator)
//   i_din_valid  qualifies i_din; no state advances while low
//   i_din        received PRBS bit
//   i_clr_cnt    synchronous clear of o_err_count (wins over a same-cycle error)
//   o_locked     high while in LOCKED
//   o_err_pulse  one-cycle pulse, one cycle after an erroneous bit in LOCKED
//   o_err_count  saturating total error count
// -----------------------------------------------------------------------------
module prbs31_checker #(
    parameter int LOCK_COUNT  = 64,
    parameter int WIN_LOG2    = 10,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_din_valid,
    input  logic             i_din,
    input  logic             i_clr_cnt,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_err_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [15:0]       LOCK_LAST = 16'(LOCK_COUNT - 1);
    localparam logic [WIN_LOG2:0] THRESH    = (WIN_LOG2 + 1)'(LOSS_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t              r_state, w_state_nxt;
    logic [30:0]         r_hist, w_hist_nxt, w_hist_sh;
    logic [4:0]          r_load, w_load_nxt;
    logic [15:0]         r_match, w_match_nxt;
    logic [WIN_LOG2-1:0] r_win, w_win_nxt;
    logic [WIN_LOG2:0]   r_werr, w_werr_nxt, w_werr_inc;
    logic                r_locked, w_locked_nxt;
    logic                r_pulse, w_pulse_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_pred, w_bit, w_err;

    always_comb begin
        w_pred     = r_hist[27] ^ r_hist[30];
        // In LOCKED the history runs on its own prediction so a flipped input
        // bit never pollutes the replica and is counted exactly once.
        w_bit      = (r_state == ST_LOCKED) ? w_pred : i_din;
        w_hist_sh  = {r_hist[29:0], w_bit};
        w_err      = (r_state == ST_LOCKED) && (i_din != w_pred);
        w_werr_inc = r_werr + {{WIN_LOG2{1'b0}}, w_err};

        w_state_nxt  = r_state;
        w_hist_nxt   = r_hist;
        w_load_nxt   = r_load;
        w_match_nxt  = r_match;
        w_win_nxt    = r_win;
        w_werr_nxt   = r_werr;
        w_locked_nxt = r_locked;
        w_pulse_nxt  = 1'b0;
        w_cnt_nxt    = r_cnt;

        if (i_din_valid) begin
            w_hist_nxt = w_hist_sh;
            case (r_state)
                ST_HUNT: begin
                    if (r_load == 5'd30) begin
                        // 31st bit: an all-zero history is the LFSR lock-up
                        // state and can never predict a real stream.
                        w_load_nxt = 5'd0;
                        if (|w_hist_sh) begin
                            w_state_nxt = ST_SYNC;
                            w_match_nxt = 16'd0;
                        end
                    end else begin
                        w_load_nxt = r_load + 5'd1;
                    end
                end
                ST_SYNC: begin
                    if (~|w_hist_sh) begin
                        w_state_nxt = ST_HUNT;
                        w_load_nxt  = 5'd0;
                        w_match_nxt = 16'd0;
                    end else if (i_din == w_pred) begin
                        if (r_match == LOCK_LAST) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                            w_match_nxt  = 16'd0;
                            w_win_nxt    = '0;
                            w_werr_nxt   = '0;
                        end else begin
                            w_match_nxt = r_match + 16'd1;
                        end
                    end else begin
                        w_match_nxt = 16'd0;
                    end
                end
                ST_LOCKED: begin
                    w_pulse_nxt = w_err;
                    if (w_err && (r_cnt != CNT_MAX))
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_win_nxt = r_win + WIN_LOG2'(1);
                    // Threshold is tested on the incremented count, so an error
                    // on the window's last bit still belongs to that window.
                    if (w_werr_inc >= THRESH) begin
                        w_state_nxt  = ST_HUNT;
                        w_locked_nxt = 1'b0;
                        w_load_nxt   = 5'd0;
                        w_match_nxt  = 16'd0;
                        w_win_nxt    = '0;
                        w_werr_nxt   = '0;
                    end else if (&r_win) begin
                        w_werr_nxt = '0;
                    end else begin
                        w_werr_nxt = w_werr_inc;
                    end
                end
                default: begin
                    w_state_nxt  = ST_HUNT;
                    w_locked_nxt = 1'b0;
                    w_load_nxt   = 5'd0;
                end
            endcase
        end

        if (i_clr_cnt)
            w_cnt_nxt = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state  <= ST_HUNT;
            r_hist   <= '0;
            r_load   <= '0;
            r_match  <= '0;
            r_win    <= '0;
            r_werr   <= '0;
            r_locked <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hist   <= w_hist_nxt;
            r_load   <= w_load_nxt;
            r_match  <= w_match_nxt;
            r_win    <= w_win_nxt;
            r_werr   <= w_werr_nxt;
            r_locked <= w_locked_nxt;
            r_pulse  <= w_pulse_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign o_locked    = r_locked;
    assign o_err_pulse = r_pulse;
    assign o_err_count = r_cnt;

endmodule

// File: tb/tb_prbs31_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs31_checker
//   Drives a PRBS31 stream (30 zeros then a 1, then s[n]=s[n-28]^s[n-31]) into
//   prbs31_checker with random gaps and injected bit flips. A bit-level model
//   pushes the expected {locked, err_pulse, err_count} for every cycle into a
//   queue; a monitor pops and compares after each rising edge. Directed checks
//   cover lock timing, error counts, saturation, clear and async reset.
// -----------------------------------------------------------------------------
module tb_prbs31_checker;

    localparam int LOCK_COUNT  = 64;
    localparam int WIN_LOG2    = 10;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int WIN         = 1 << WIN_LOG2;
    localparam int NBITS       = 20000;
    localparam int M_HUNT = 0, M_SYNC = 1, M_LOCK = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             locked, err_pulse;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    prbs31_checker #(
        .LOCK_COUNT (LOCK_COUNT),
        .WIN_LOG2   (WIN_LOG2),
        .LOSS_THRESH(LOSS_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_din_valid(din_valid),
        .i_din      (din),
        .i_clr_cnt  (clr_cnt),
        .o_locked   (locked),
        .o_err_pulse(err_pulse),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lk;
        logic             ep;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    bit   stream[NBITS];
    int   sidx;
    int   npulse = 0;
    bit   seen_lock = 0;

    // ---------------- reference model (bit-list level) ----------------
    bit m_h[$];   // m_h[0] = newest received/replica bit
    int m_mode, m_load, m_match, m_win, m_werr, m_cnt;
    bit m_lock, m_pulse;

    task automatic model_reset();
        m_h.delete();
        for (int i = 0; i < 31; i++) m_h.push_back(1'b0);
        m_mode = M_HUNT; m_load = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_cnt = 0; m_lock = 0; m_pulse = 0;
    endtask

    task automatic model_step(bit v, bit d, bit c);
        bit p, x;
        int ones;
        m_pulse = 0;
        if (v) begin
            p = m_h[27] ^ m_h[30];
            x = (m_mode == M_LOCK) ? p : d;
            m_h.push_front(x);
            void'(m_h.pop_back());
            ones = 0;
            foreach (m_h[i]) ones += int'(m_h[i]);
            if (m_mode == M_HUNT) begin
                m_load++;
                if (m_load == 31) begin
                    m_load = 0;
                    if (ones != 0) begin m_mode = M_SYNC; m_match = 0; end
                end
            end else if (m_mode == M_SYNC) begin
                if (ones == 0) begin
                    m_mode = M_HUNT; m_load = 0;
                end else if (d == p) begin
                    m_match++;
                    if (m_match == LOCK_COUNT) begin
                        m_mode = M_LOCK; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                if (d != p) begin
                    m_pulse = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_werr++;
                end
                m_win++;
                if (m_werr >= LOSS_THRESH) begin
                    m_mode = M_HUNT; m_load = 0; m_win = 0; m_werr = 0;
                end else if (m_win == WIN) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        if (c) m_cnt = 0;
        m_lock = (m_mode == M_LOCK);
        exp_q.push_back(exp_t'{m_lock, m_pulse, CNT_W'(m_cnt)});
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (locked === 1'b1) seen_lock = 1;
            if (err_pulse === 1'b1) npulse++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({locked, err_pulse, err_count} !== e) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got lk=%b ep=%b cnt=%0d want lk=%b ep=%b cnt=%0d",
                             $time, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic step(bit v, bit d, bit c);
        @(negedge clk);
        din_valid = v; din = d; clr_cnt = c;
        model_step(v, d, c);
    endtask

    // Next stream bit (optionally flipped) when valid, random junk otherwise.
    task automatic send(bit v, bit flip, bit c);
        bit d;
        if (v) begin
            d = stream[sidx] ^ flip;
            sidx++;
        end else begin
            d = 1'($urandom);
        end
        step(v, d, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(bit pre);
        @(posedge clk);
        #3;
        if (pre) begin
            chk("pre_rst_locked", locked, 1);
            chk("pre_rst_pulse", err_pulse, 1);
            chk("pre_rst_cnt", err_count, 1);
        end
        rst = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_cnt", err_count, 0);
        model_reset();
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        sidx = 0;
        seen_lock = 0;
    endtask

    task automatic lock_seq();
        for (int k = 0; k < 95; k++) begin
            send(1, 0, 0);
            if (k == 93) begin settle(); chk("lock_bit93", locked, 0); end
            if (k == 94) begin settle(); chk("lock_bit94", locked, 1); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n, p0, guard;
        bit v;
        for (int i = 0; i < NBITS; i++) begin
            if (i < 30)       stream[i] = 1'b0;
            else if (i == 30) stream[i] = 1'b1;
            else              stream[i] = stream[i-28] ^ stream[i-31];
        end
        model_reset();

        // 1. reset, lock timing, long clean run
        do_reset(0);
        lock_seq();
        repeat (10000) send(1, 0, 0);
        settle();
        chk("clean_cnt", err_count, 0);
        chk("clean_locked", locked, 1);

        // 2. single flipped bit
        p0 = npulse;
        repeat (199) send(1, 0, 0);
        send(1, 1, 0);
        settle();
        chk("single_pulse_lat", err_pulse, 1);
        repeat (5) send(1, 0, 0);
        settle();
        chk("single_npulse", npulse - p0, 1);
        chk("single_cnt", err_count, 1);
        chk("single_locked", locked, 1);

        // 3. burst of LOSS_THRESH errors inside one window, then relock
        send(1, 0, 1);
        settle();
        chk("clr_before_burst", err_count, 0);
        guard = 0;
        while (m_win != 100 && guard < 2 * WIN) begin send(1, 0, 0); guard++; end
        repeat (LOSS_THRESH - 1) send(1, 1, 0);
        settle();
        chk("burst_still_locked", locked, 1);
        send(1, 1, 0);
        settle();
        chk("burst_lost", locked, 0);
        chk("burst_cnt", err_count, LOSS_THRESH);
        n = 0;
        while (locked !== 1'b1 && n < 300) begin send(1, 0, 0); settle(); n++; end
        chk("relock_bits", n, 95);

        // 4. all-zero input never locks
        do_reset(0);
        repeat (5000) step(1, 0, 0);
        settle();
        chk("zero_never_locked", seen_lock, 0);
        chk("zero_cnt", err_count, 0);

        // 5. random valid gaps, lock timing in valid bits
        do_reset(0);
        n = 0; guard = 0;
        while (locked !== 1'b1 && guard < 2000) begin
            v = ($urandom_range(0, 3) != 0);
            send(v, 0, 0);
            if (v) n++;
            settle();
            guard++;
        end
        chk("gap_lock_bits", n, 95);
        repeat (300) send($urandom_range(0, 2) != 0, 0, 0);

        // 6. saturation, clear, clear coincident with error
        for (int i = 0; i < 20; i++) begin
            repeat (199) send(1, 0, 0);
            send(1, 1, 0);
        end
        settle();
        chk("sat_cnt", err_count, CNT_MAX);
        chk("sat_locked", locked, 1);
        send(1, 0, 1);
        settle();
        chk("clr_cnt", err_count, 0);
        repeat (10) send(1, 0, 0);
        send(1, 1, 1);
        settle();
        chk("clr_err_cnt", err_count, 0);
        chk("clr_err_pulse", err_pulse, 1);

        // 7. async reset mid-LOCKED with a pulse in flight, then relock
        repeat (50) send(1, 0, 0);
        send(1, 1, 0);
        do_reset(1);
        lock_seq();
        repeat (20) send(1, 0, 0);
        settle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin settle(); guard++; end
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
